latency_decoding: RTL and testbench
===================================

Name: latency_decoding

Overview:
- Inverse of the SNN latency (time-to-first-spike) encoder: collects one spike frame of T_STEPS time steps across N_NEURONS lanes and reconstructs one magnitude per neuron.
- Per neuron it records the step of the first spike. It then emits value = (T_STEPS − t_first) × scale as a stream.
- Sits after the spike fabric, closing the hardware encode/decode validation loop against the software model.

Parameters:
N_NEURONS, 8, number of spike lanes per frame
T_STEPS, 16, time steps per frame (≥2)
TW, $clog2(T_STEPS+1), width of step/weight values
SCALE_W, 22, width of unsigned scale factor
DOUT_W, TW+SCALE_W, width of decoded value
IDX_W, $clog2(N_NEURONS), width of neuron index

Ports:
ap_clk  in  1  clock, all logic rising-edge
ap_rst  in  1  asynchronous, active-high reset
ap_start  in  1  frame start pulse, honoured only in IDLE
scale  in  SCALE_W  unsigned scale, sampled on accepted ap_start
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse after last value handshakes
spk_vld  in  1  spike vector valid
spk_rdy  out  1  high only in COLLECT
spk_vec  in  N_NEURONS  spike bits for current step, bit i = neuron i
out_vld  out  1  decoded value valid
out_rdy  in  1  downstream ready
out_idx  out  IDX_W  neuron index of out_data
out_data  out  DOUT_W  decoded unsigned value
out_nospk  out  1  neuron never spiked, so out_data = 0

Behaviour:
- Reset (async assert; deassert sampled on ap_clk):
  - state = IDLE; ap_idle = 1.
  - ap_done, spk_rdy, out_vld, out_nospk = 0; out_idx, out_data = 0.
  - Step counter = 0; all first-spike flags cleared; scale register = 0.
- States: IDLE → COLLECT → EMIT → IDLE.
- IDLE:
  - On ap_start = 1: latch scale, clear all fired flags and t_first registers, step = 0, go to COLLECT.
  - ap_start in any other state is ignored.
- COLLECT:
  - spk_rdy = 1. A step is accepted when spk_vld & spk_rdy.
  - On accept, for each neuron i with spk_vec[i] = 1 and fired[i] = 0: t_first[i] = step, fired[i] = 1.
  - Later spikes on an already-fired neuron are ignored (first spike wins).
  - Multiple neurons may fire on the same step.
  - The step counter increments per accept only; spk_vld low stalls without penalty.
  - On accept with step = T_STEPS−1: go to EMIT, n = 0; spk_rdy drops the next cycle.
- EMIT:
  - Output registered, one value per neuron in index order 0..N_NEURONS−1.
  - Entry cycle: load out_idx = 0, out_data, out_nospk; out_vld rises the next cycle.
  - Arithmetic: weight = T_STEPS − t_first, range 1..T_STEPS in TW bits, unsigned. out_data = weight × scale, exact in DOUT_W bits (no truncation or saturation).
  - fired = 0 → out_data = 0, out_nospk = 1.
  - While out_vld & !out_rdy, out_idx, out_data and out_nospk are held stable.
  - On handshake:
    - If n < N_NEURONS−1: the next neuron is loaded in the same cycle, so back-to-back throughput is 1 value/cycle.
    - If n = N_NEURONS−1: out_vld drops, ap_done pulses one cycle, state = IDLE.
- Latency: first out_vld two cycles after the final spike-step accept.
- Reset mid-frame: immediate abort to the reset state; partial frame is discarded and no ap_done is produced.
- scale changes after ap_start have no effect on the current frame.

Decomposition:
- Shared package:
  - State enum (IDLE, COLLECT, EMIT).
  - Default N_NEURONS, T_STEPS, SCALE_W.
  - TW/IDX_W/DOUT_W derivation functions, common with the encoder.
- Sub-module latency_weight_mul:
  - Combinational unsigned TW × SCALE_W multiplier producing DOUT_W.
  - Kept separate so it maps onto DSP like the encoder's multiplier.

Test Plan:
- Defaults, scale = 100. Neuron 0 spikes at step 0, neuron 3 at step 15, neuron 7 at step 4, others silent → idx0 = 1600; idx3 = 100; idx7 = 1200; idx1, 2, 4, 5, 6 = 0 with out_nospk = 1. Exactly 8 outputs, then one ap_done pulse.
- Neuron 2 spikes at steps 3, 5 and 9 → out_data for idx2 = 1300 (first spike only).
- spk_vld toggled every other cycle during COLLECT → identical results; exactly 16 accepts before spk_rdy drops.
- out_rdy held low 5 cycles at idx4 → out_idx, out_data and out_nospk stable throughout. With out_rdy held high, the 8 values arrive on 8 consecutive cycles.
- scale = 2^22−1, all neurons fire at step 0 → each out_data = 16 × 4194303 = 67108848 with no overflow. ap_start asserted during EMIT is ignored.
- ap_rst asserted after 7 accepted steps → all outputs at reset values immediately. A new frame afterwards with no spikes → eight zeros with out_nospk = 1.

Source files
------------

// File: rtl/latency_decoding_pkg.sv
// rtl/latency_decoding_pkg.sv - shared state type, defaults and width helpers for the latency decoder
package latency_decoding_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  localparam int DEF_N_NEURONS = 8;
  localparam int DEF_T_STEPS   = 16;
  localparam int DEF_SCALE_W   = 22;

  // Step/weight width must also hold T_STEPS itself, the largest weight.
  function automatic int calc_tw(input int t_steps);
    return $clog2(t_steps + 1);
  endfunction

  function automatic int calc_idx_w(input int n_neurons);
    return (n_neurons > 1) ? $clog2(n_neurons) : 1;
  endfunction

  function automatic int calc_dout_w(input int t_steps, input int scale_w);
    return calc_tw(t_steps) + scale_w;
  endfunction

endpackage

// File: rtl/latency_weight_mul.sv
// rtl/latency_weight_mul.sv - exact unsigned weight x scale product
module latency_weight_mul
  import latency_decoding_pkg::*;
#(
  parameter int TW      = calc_tw(DEF_T_STEPS),
  parameter int SCALE_W = DEF_SCALE_W,
  parameter int DOUT_W  = TW + SCALE_W
) (
  input  logic [TW-1:0]      i_weight,
  input  logic [SCALE_W-1:0] i_scale,
  output logic [DOUT_W-1:0]  o_product
);

  assign o_product = DOUT_W'(i_weight) * DOUT_W'(i_scale);

endmodule

// File: rtl/latency_decoding.sv
// rtl/latency_decoding.sv - collects a time-to-first-spike frame and streams one decoded magnitude per neuron
module latency_decoding
  import latency_decoding_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int T_STEPS   = DEF_T_STEPS,
  parameter int TW        = calc_tw(T_STEPS),
  parameter int SCALE_W   = DEF_SCALE_W,
  parameter int DOUT_W    = TW + SCALE_W,
  parameter int IDX_W     = calc_idx_w(N_NEURONS)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  input  logic [SCALE_W-1:0]   scale,
  output logic                 ap_idle,
  output logic                 ap_done,
  input  logic                 spk_vld,
  output logic                 spk_rdy,
  input  logic [N_NEURONS-1:0] spk_vec,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [IDX_W-1:0]     out_idx,
  output logic [DOUT_W-1:0]    out_data,
  output logic                 out_nospk
);

  localparam logic [TW-1:0]    LAST_STEP   = TW'(T_STEPS - 1);
  localparam logic [TW-1:0]    FULL_WEIGHT = TW'(T_STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_NEURONS - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [TW-1:0]        r_step;
  logic [N_NEURONS-1:0] r_fired;
  logic [TW-1:0]        r_tfirst [N_NEURONS];
  logic [SCALE_W-1:0]   r_scale;
  logic                 r_out_vld;
  logic                 r_out_nospk;
  logic                 r_done;
  logic [IDX_W-1:0]     r_out_idx;
  logic [DOUT_W-1:0]    r_out_data;

  logic                 w_accept;
  logic                 w_last_accept;
  logic                 w_handshake;
  logic                 w_last_handshake;
  logic                 w_load;
  logic [IDX_W-1:0]     w_sel;
  logic [TW-1:0]        w_weight;
  logic [DOUT_W-1:0]    w_product;

  assign w_accept         = (r_state == ST_COLLECT) && spk_vld;
  assign w_last_accept    = w_accept && (r_step == LAST_STEP);
  assign w_handshake      = (r_state == ST_EMIT) && r_out_vld && out_rdy;
  assign w_last_handshake = w_handshake && (r_out_idx == LAST_IDX);
  // Entry into EMIT loads neuron 0; every non-final handshake loads the next neuron.
  assign w_load   = (r_state == ST_EMIT) && (!r_out_vld || (w_handshake && !w_last_handshake));
  assign w_sel    = r_out_vld ? (r_out_idx + IDX_W'(1)) : '0;
  assign w_weight = FULL_WEIGHT - r_tfirst[w_sel];

  latency_weight_mul #(
    .TW      (TW),
    .SCALE_W (SCALE_W),
    .DOUT_W  (DOUT_W)
  ) u_mul (
    .i_weight  (w_weight),
    .i_scale   (r_scale),
    .o_product (w_product)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (ap_start)         w_next_state = ST_COLLECT;
      ST_COLLECT: if (w_last_accept)    w_next_state = ST_EMIT;
      ST_EMIT:    if (w_last_handshake) w_next_state = ST_IDLE;
      default:                          w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_step      <= '0;
      r_fired     <= '0;
      r_scale     <= '0;
      r_out_vld   <= 1'b0;
      r_out_nospk <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) r_tfirst[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE && ap_start) begin
        r_scale <= scale;
        r_step  <= '0;
        r_fired <= '0;
        for (int i = 0; i < N_NEURONS; i++) r_tfirst[i] <= '0;
      end
      if (w_accept) begin
        r_step <= r_step + TW'(1);
        for (int i = 0; i < N_NEURONS; i++) begin
          if (spk_vec[i] && !r_fired[i]) begin
            r_tfirst[i] <= r_step;
            r_fired[i]  <= 1'b1;
          end
        end
      end
      if (w_load) begin
        r_out_vld   <= 1'b1;
        r_out_idx   <= w_sel;
        r_out_data  <= r_fired[w_sel] ? w_product : '0;
        r_out_nospk <= !r_fired[w_sel];
      end else if (w_last_handshake) begin
        r_out_vld <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end

  assign ap_idle   = (r_state == ST_IDLE);
  assign spk_rdy   = (r_state == ST_COLLECT);
  assign ap_done   = r_done;
  assign out_vld   = r_out_vld;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign out_nospk = r_out_nospk;

endmodule

// File: tb/tb_latency_decoding.sv
// tb/tb_latency_decoding.sv - directed self-checking bench for latency_decoding
module tb_latency_decoding;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        ap_start = 1'b0;
  logic [21:0] scale = '0;
  logic        ap_idle, ap_done, spk_rdy, out_vld, out_nospk;
  logic        spk_vld = 1'b0;
  logic [7:0]  spk_vec = '0;
  logic        out_rdy = 1'b1;
  logic [2:0]  out_idx;
  logic [26:0] out_data;

  int total = 0;
  int bad = 0;

  logic [7:0]  vecs [16];
  logic [26:0] exp_data [8];
  logic        exp_nospk [8];
  logic [26:0] got_data [8];
  logic        got_nospk [8];
  int          got_idx [8];
  int          got_cyc [8];
  int          n_got, n_done, n_acc, first_vld_cyc, stall_bad, stall_seen, tail_vld;
  logic        post_rdy, post_vld;
  bit          poke_start = 1'b0;

  latency_decoding dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .scale     (scale),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .spk_vld   (spk_vld),
    .spk_rdy   (spk_rdy),
    .spk_vec   (spk_vec),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_nospk (out_nospk)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_vecs();
    for (int i = 0; i < 16; i++) vecs[i] = 8'h00;
  endtask

  task automatic start_frame(input logic [21:0] s);
    @(negedge ap_clk);
    scale = s;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
  endtask

  task automatic run_collect(input bit toggle, input int max_acc);
    int cyc;
    cyc = 0;
    n_acc = 0;
    while (n_acc < max_acc && cyc < 200) begin
      @(negedge ap_clk);
      spk_vld = toggle ? (cyc % 2 == 0) : 1'b1;
      spk_vec = vecs[n_acc];
      if (spk_vld && spk_rdy) n_acc++;
      cyc++;
    end
    @(negedge ap_clk);
    spk_vld = 1'b0;
    spk_vec = 8'h00;
    post_rdy = spk_rdy;
    post_vld = out_vld;
  endtask

  task automatic collect_outputs(input int stall_at, input int stall_len);
    int cyc;
    int left;
    logic [26:0] h_data;
    logic [2:0]  h_idx;
    logic        h_nospk;
    cyc = 0;
    left = stall_len;
    h_data = '0;
    h_idx = '0;
    h_nospk = 1'b0;
    n_got = 0;
    n_done = 0;
    first_vld_cyc = -1;
    stall_bad = 0;
    stall_seen = 0;
    tail_vld = 0;
    while (n_got < 8 && cyc < 100) begin
      @(negedge ap_clk);
      if (ap_done) n_done++;
      if (poke_start) ap_start = (cyc == 2);
      if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_vld && int'(out_idx) == stall_at) begin
        if (left == stall_len) begin
          h_data = out_data;
          h_idx = out_idx;
          h_nospk = out_nospk;
        end else if ({out_data, out_idx, out_nospk} !== {h_data, h_idx, h_nospk}) begin
          stall_bad++;
        end
        stall_seen++;
        out_rdy = (left == 0);
        if (left > 0) left--;
      end else begin
        out_rdy = 1'b1;
      end
      if (out_vld && out_rdy) begin
        got_idx[n_got] = int'(out_idx);
        got_data[n_got] = out_data;
        got_nospk[n_got] = out_nospk;
        got_cyc[n_got] = cyc;
        n_got++;
      end
      cyc++;
    end
    ap_start = 1'b0;
    repeat (3) begin
      @(negedge ap_clk);
      if (ap_done) n_done++;
      if (out_vld) tail_vld++;
    end
    out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    @(negedge ap_clk);
    total++;
    if ({ap_idle, ap_done, spk_rdy, out_vld, out_nospk} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=10000", {ap_idle, ap_done, spk_rdy, out_vld, out_nospk});
    end
    total++;
    if ({out_idx, out_data} !== 30'd0) begin
      bad++;
      $display("FAIL reset_data got idx=%0d data=%0d want 0/0", out_idx, out_data);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_vecs();
    vecs[0] = 8'h01;
    vecs[4] = 8'h80;
    vecs[15] = 8'h08;
    exp_data = '{27'd1600, 27'd0, 27'd0, 27'd100, 27'd0, 27'd0, 27'd0, 27'd1200};
    exp_nospk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    start_frame(22'd100);
    scale = 22'd7;
    run_collect(1'b0, 16);
    total++;
    if (post_vld !== 1'b0 || post_rdy !== 1'b0) begin
      bad++;
      $display("FAIL basic_entry got vld=%b rdy=%b want 0/0", post_vld, post_rdy);
    end
    collect_outputs(-1, 0);
    total++;
    if (n_got !== 8) begin bad++; $display("FAIL basic_count got=%0d want=8", n_got); end
    for (int i = 0; i < n_got; i++) begin
      total++;
      if (got_idx[i] !== i || got_data[i] !== exp_data[i] || got_nospk[i] !== exp_nospk[i]) begin
        bad++;
        $display("FAIL basic_val[%0d] got idx=%0d data=%0d nospk=%b want idx=%0d data=%0d nospk=%b",
                 i, got_idx[i], got_data[i], got_nospk[i], i, exp_data[i], exp_nospk[i]);
      end
    end
    total++;
    if (first_vld_cyc !== 0) begin bad++; $display("FAIL basic_latency got=%0d want=0", first_vld_cyc); end
    total++;
    if (n_got == 8 && got_cyc[7] - got_cyc[0] !== 7) begin
      bad++;
      $display("FAIL basic_b2b got span=%0d want=7", got_cyc[7] - got_cyc[0]);
    end
    total++;
    if (n_done !== 1 || tail_vld !== 0) begin
      bad++;
      $display("FAIL basic_done got done=%0d tailvld=%0d want 1/0", n_done, tail_vld);
    end
    total++;
    if (ap_idle !== 1'b1) begin bad++; $display("FAIL basic_idle got=%b want=1", ap_idle); end
  endtask

  task automatic test_first_spike_toggle();
    clear_vecs();
    vecs[0] = 8'h01;
    vecs[3] = 8'h04;
    vecs[4] = 8'h80;
    vecs[5] = 8'h04;
    vecs[9] = 8'h04;
    vecs[10] = 8'h01;
    vecs[15] = 8'h08;
    exp_data = '{27'd1600, 27'd0, 27'd1300, 27'd100, 27'd0, 27'd0, 27'd0, 27'd1200};
    exp_nospk = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    start_frame(22'd100);
    run_collect(1'b1, 16);
    total++;
    if (n_acc !== 16 || post_rdy !== 1'b0) begin
      bad++;
      $display("FAIL toggle_accepts got acc=%0d rdy=%b want 16/0", n_acc, post_rdy);
    end
    collect_outputs(-1, 0);
    total++;
    if (n_got !== 8 || n_done !== 1) begin
      bad++;
      $display("FAIL toggle_count got=%0d done=%0d want 8/1", n_got, n_done);
    end
    for (int i = 0; i < n_got; i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_nospk[i] !== exp_nospk[i]) begin
        bad++;
        $display("FAIL toggle_val[%0d] got data=%0d nospk=%b want data=%0d nospk=%b",
                 i, got_data[i], got_nospk[i], exp_data[i], exp_nospk[i]);
      end
    end
  endtask

  task automatic test_stall();
    clear_vecs();
    vecs[0] = 8'h01;
    vecs[4] = 8'h80;
    vecs[15] = 8'h08;
    exp_data = '{27'd1600, 27'd0, 27'd0, 27'd100, 27'd0, 27'd0, 27'd0, 27'd1200};
    exp_nospk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    start_frame(22'd100);
    run_collect(1'b0, 16);
    collect_outputs(4, 5);
    total++;
    if (stall_seen !== 6 || stall_bad !== 0) begin
      bad++;
      $display("FAIL stall_hold got seen=%0d unstable=%0d want 6/0", stall_seen, stall_bad);
    end
    total++;
    if (n_got !== 8 || n_done !== 1) begin
      bad++;
      $display("FAIL stall_count got=%0d done=%0d want 8/1", n_got, n_done);
    end
    for (int i = 0; i < n_got; i++) begin
      total++;
      if (got_idx[i] !== i || got_data[i] !== exp_data[i] || got_nospk[i] !== exp_nospk[i]) begin
        bad++;
        $display("FAIL stall_val[%0d] got idx=%0d data=%0d nospk=%b want data=%0d nospk=%b",
                 i, got_idx[i], got_data[i], got_nospk[i], exp_data[i], exp_nospk[i]);
      end
    end
  endtask

  task automatic test_max_scale();
    clear_vecs();
    vecs[0] = 8'hFF;
    vecs[1] = 8'hFF;
    start_frame(22'h3FFFFF);
    run_collect(1'b0, 16);
    poke_start = 1'b1;
    collect_outputs(-1, 0);
    poke_start = 1'b0;
    total++;
    if (n_got !== 8 || n_done !== 1) begin
      bad++;
      $display("FAIL max_count got=%0d done=%0d want 8/1", n_got, n_done);
    end
    for (int i = 0; i < n_got; i++) begin
      total++;
      if (got_data[i] !== 27'd67108848 || got_nospk[i] !== 1'b0) begin
        bad++;
        $display("FAIL max_val[%0d] got data=%0d nospk=%b want data=67108848 nospk=0",
                 i, got_data[i], got_nospk[i]);
      end
    end
    total++;
    if (ap_idle !== 1'b1 || spk_rdy !== 1'b0) begin
      bad++;
      $display("FAIL max_start_ignored got idle=%b rdy=%b want 1/0", ap_idle, spk_rdy);
    end
  endtask

  task automatic test_reset_midframe();
    clear_vecs();
    vecs[1] = 8'hFF;
    start_frame(22'd9);
    run_collect(1'b0, 7);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    total++;
    if ({ap_idle, ap_done, spk_rdy, out_vld, out_nospk} !== 5'b10000 || {out_idx, out_data} !== 30'd0) begin
      bad++;
      $display("FAIL midreset got ctrl=%b idx=%0d data=%0d want 10000/0/0",
               {ap_idle, ap_done, spk_rdy, out_vld, out_nospk}, out_idx, out_data);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    clear_vecs();
    start_frame(22'd55);
    run_collect(1'b0, 16);
    collect_outputs(-1, 0);
    total++;
    if (n_got !== 8 || n_done !== 1) begin
      bad++;
      $display("FAIL zero_count got=%0d done=%0d want 8/1", n_got, n_done);
    end
    for (int i = 0; i < n_got; i++) begin
      total++;
      if (got_idx[i] !== i || got_data[i] !== 27'd0 || got_nospk[i] !== 1'b1) begin
        bad++;
        $display("FAIL zero_val[%0d] got idx=%0d data=%0d nospk=%b want idx=%0d data=0 nospk=1",
                 i, got_idx[i], got_data[i], got_nospk[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_first_spike_toggle();
    test_stall();
    test_max_scale();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
